// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: counter constants, PC index/tag slicing
// and the saturating counter step.
package bp_pkg;

  function automatic int unsigned cnt_max(int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic int unsigned cnt_weak_t(int unsigned bits);
    return 32'd1 << (bits - 32'd1);
  endfunction

  function automatic int unsigned cnt_weak_nt(int unsigned bits);
    return (32'd1 << (bits - 32'd1)) - 32'd1;
  endfunction

  // Word-aligned PCs: the low two bits never take part in indexing.
  function automatic logic [63:0] pc_idx(logic [63:0] pc, int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(logic [63:0] pc, int unsigned idx_w);
    return pc >> (idx_w + 32'd2);
  endfunction

  function automatic int unsigned sat_step(int unsigned cnt, logic taken, int unsigned bits);
    if (taken) begin
      return (cnt == cnt_max(bits)) ? cnt : cnt + 32'd1;
    end
    return (cnt == 32'd0) ? cnt : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next value of a saturating direction counter; force_max_i pins it
// to strongly taken for unconditional jumps.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CntBits = 2
) (
  input  logic [CntBits-1:0] cnt_i,
  input  logic               taken_i,
  input  logic               force_max_i,
  output logic [CntBits-1:0] cnt_o
);

  localparam logic [CntBits-1:0] CntMax = CntBits'(cnt_max(CntBits));

  logic [31:0] cnt_ext;

  always_comb begin
    cnt_ext = {{(32 - CntBits){1'b0}}, cnt_i};
    cnt_o   = force_max_i ? CntMax : CntBits'(sat_step(cnt_ext, taken_i, CntBits));
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: zero-latency lookup for IF, trained by EX,
// with mispredict/redirect generation and saturating performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned ENTRIES      = 64,
  parameter int unsigned CNT_BITS     = 2,
  parameter bit          PREDICT_JALR = 1'b0,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  output logic [ADDR_W-1:0] if_pred_target,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_is_jump,
  input  logic              ex_is_jalr,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_BITS-1:0] CntMax    = CNT_BITS'(cnt_max(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CntWeakT  = CNT_BITS'(cnt_weak_t(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CntWeakNt = CNT_BITS'(cnt_weak_nt(CNT_BITS));

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  logic [PERF_W-1:0] perf_br_q, perf_mp_q;

  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit, ex_jump, ex_fire, upd, tbl_we;
  logic [CNT_BITS-1:0] cnt_hit_d, cnt_d;

  assign if_idx = IDX_W'(pc_idx(64'(if_pc), IDX_W));
  assign if_tag = TAG_W'(pc_tag(64'(if_pc), IDX_W));
  assign ex_idx = IDX_W'(pc_idx(64'(ex_pc), IDX_W));
  assign ex_tag = TAG_W'(pc_tag(64'(ex_pc), IDX_W));

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  always_comb begin
    if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    if_pred_taken  = if_hit && cnt_q[if_idx][CNT_BITS-1];
    if_pred_target = if_pred_taken ? target_q[if_idx] : if_pc + ADDR_W'(4);
  end

  bp_sat_counter #(
    .CntBits (CNT_BITS)
  ) u_sat_counter (
    .cnt_i       (cnt_q[ex_idx]),
    .taken_i     (ex_taken),
    .force_max_i (ex_jump),
    .cnt_o       (cnt_hit_d)
  );

  always_comb begin
    ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_jump = ex_is_jump || (ex_is_jalr && PREDICT_JALR);
    ex_fire = ex_valid && !ex_stall;
    upd     = ex_fire && !(ex_is_jalr && !PREDICT_JALR);
    // A not-taken miss leaves the table untouched.
    tbl_we  = upd && (ex_hit || ex_taken);
    cnt_d   = ex_hit ? cnt_hit_d : (ex_jump ? CntMax : CntWeakT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CntWeakNt;
      end
    end else if (tbl_we) begin
      valid_q[ex_idx] <= 1'b1;
      tag_q[ex_idx]   <= ex_tag;
      cnt_q[ex_idx]   <= cnt_d;
      if (ex_taken) begin
        target_q[ex_idx] <= ex_target;
      end
    end
  end

  always_comb begin
    mispredict  = ex_fire && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_target != ex_pred_target)));
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (ex_fire && (perf_br_q != '1)) begin
        perf_br_q <= perf_br_q + PERF_W'(1);
      end
      if (mispredict && (perf_mp_q != '1)) begin
        perf_mp_q <= perf_mp_q + PERF_W'(1);
      end
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with default parameters (64 entries, 2-bit
// counters, jalr not predicted); expected values are hand-computed.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid, ex_stall, ex_is_jump, ex_is_jalr, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, perf_branches, perf_mispredicts;

  int tests_run = 0;
  int tests_failed = 0;

  branch_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_is_jump       (ex_is_jump),
    .ex_is_jalr       (ex_is_jalr),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid = 0; ex_stall = 0; ex_is_jump = 0; ex_is_jalr = 0; ex_taken = 0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic jump, input logic jalr,
                         input logic taken, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
    ex_valid = 1; ex_stall = 0; ex_pc = pc; ex_is_jump = jump; ex_is_jalr = jalr;
    ex_taken = taken; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic taken,
                      input logic [31:0] tgt);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, if_pred_taken}, {31'd0, taken});
    chk({tag, "_target"}, if_pred_target, tgt);
  endtask

  initial begin
    rst_n = 0;
    if_pc = 32'h100;
    idle_ex();
    #3;
    look("reset_lookup", 32'h100, 0, 32'h104);
    chk("reset_perf_br", perf_branches, 0);
    chk("reset_perf_mp", perf_mispredicts, 0);
    chk("reset_mispredict", {31'd0, mispredict}, 0);
    @(negedge clk);
    rst_n = 1;
    step();

    // Taken branch misses and allocates weakly taken; same-cycle lookup sees old data.
    resolve(32'h100, 0, 0, 1, 32'h80, 0, 32'h0);
    chk("alloc_mispredict", {31'd0, mispredict}, 1);
    chk("alloc_redirect", redirect_pc, 32'h80);
    look("no_bypass", 32'h100, 0, 32'h104);
    step();
    idle_ex();
    look("after_alloc", 32'h100, 1, 32'h80);
    chk("alloc_perf_mp", perf_mispredicts, 1);
    chk("alloc_perf_br", perf_branches, 1);

    // Not-taken x3: 10 -> 01 -> 00 -> 00.
    resolve(32'h100, 0, 0, 0, 32'h80, 1, 32'h80);
    chk("nt1_mispredict", {31'd0, mispredict}, 1);
    chk("nt1_redirect", redirect_pc, 32'h104);
    step();
    look("nt1_lookup", 32'h100, 0, 32'h104);
    resolve(32'h100, 0, 0, 0, 32'h80, 0, 32'h104);
    chk("nt2_mispredict", {31'd0, mispredict}, 0);
    chk("nt2_redirect", redirect_pc, 0);
    step();
    resolve(32'h100, 0, 0, 0, 32'h80, 0, 32'h104);
    step();
    // Saturated at 00, one taken only reaches 01.
    resolve(32'h100, 0, 0, 1, 32'h80, 0, 32'h104);
    chk("sat_taken_mispredict", {31'd0, mispredict}, 1);
    step();
    idle_ex();
    look("sat_lookup", 32'h100, 0, 32'h104);
    chk("sat_perf_br", perf_branches, 5);
    chk("sat_perf_mp", perf_mispredicts, 3);

    // jal allocates strongly taken: one not-taken hit leaves it predicted taken.
    resolve(32'h200, 1, 0, 1, 32'h40, 0, 32'h204);
    chk("jal_redirect", redirect_pc, 32'h40);
    step();
    idle_ex();
    look("jal_lookup", 32'h200, 1, 32'h40);
    resolve(32'h200, 0, 0, 0, 32'h40, 1, 32'h40);
    step();
    idle_ex();
    look("jal_strong", 32'h200, 1, 32'h40);
    // Aliasing PC replaces the line.
    resolve(32'h300, 0, 0, 1, 32'h300, 0, 32'h304);
    step();
    idle_ex();
    look("alias_old", 32'h200, 0, 32'h204);
    look("alias_new", 32'h300, 1, 32'h300);
    chk("alias_perf_br", perf_branches, 8);
    chk("alias_perf_mp", perf_mispredicts, 6);

    // Held in stall for three edges, then released: exactly one update.
    resolve(32'h400, 0, 0, 1, 32'h500, 0, 32'h404);
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_mispredict", {31'd0, mispredict}, 0);
      step();
    end
    look("stall_lookup", 32'h400, 0, 32'h404);
    chk("stall_perf_br", perf_branches, 8);
    ex_stall = 0;
    #1;
    chk("release_mispredict", {31'd0, mispredict}, 1);
    chk("release_redirect", redirect_pc, 32'h500);
    step();
    idle_ex();
    look("release_lookup", 32'h400, 1, 32'h500);
    chk("release_perf_br", perf_branches, 9);
    chk("release_perf_mp", perf_mispredicts, 7);

    // jalr is never trained.
    resolve(32'h600, 0, 1, 1, 32'h700, 0, 32'h604);
    chk("jalr_mispredict", {31'd0, mispredict}, 1);
    chk("jalr_redirect", redirect_pc, 32'h700);
    step();
    idle_ex();
    look("jalr_lookup", 32'h600, 0, 32'h604);
    resolve(32'h600, 0, 1, 1, 32'h700, 1, 32'h700);
    chk("jalr_correct", {31'd0, mispredict}, 0);
    step();
    idle_ex();
    // Wrong target with matching direction still mispredicts.
    resolve(32'h400, 0, 0, 1, 32'h520, 1, 32'h500);
    chk("target_mispredict", {31'd0, mispredict}, 1);
    chk("target_redirect", redirect_pc, 32'h520);
    step();
    idle_ex();
    look("retarget_lookup", 32'h400, 1, 32'h520);
    chk("pre_rst_perf_br", perf_branches, 12);

    // Asynchronous reset away from the clock edge.
    #2;
    rst_n = 0;
    #1;
    look("async_rst_400", 32'h400, 0, 32'h404);
    look("async_rst_300", 32'h300, 0, 32'h304);
    chk("async_rst_perf_br", perf_branches, 0);
    chk("async_rst_perf_mp", perf_mispredicts, 0);
    @(negedge clk);
    rst_n = 1;
    resolve(32'h100, 1, 0, 1, 32'h900, 0, 32'h104);
    step();
    idle_ex();
    look("post_rst_update", 32'h100, 1, 32'h900);
    chk("post_rst_perf_br", perf_branches, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch/jump predictor for the 5-stage RISC-V pipeline.
- Sits beside the IF stage. It gives a combinational next-PC prediction for the current fetch PC, and is trained by the resolving EX stage.
- Replaces "always predict not-taken, flush on every taken branch/jal". IF uses the prediction; EX compares against it and raises a single mispredict/redirect.
- Direct-mapped table of ENTRIES lines. Each line holds valid, tag, target and a CNT_BITS saturating counter. Includes performance counters.

Parameters:
- ADDR_W, 32, PC width in bits (byte address, bits [1:0] ignored).
- ENTRIES, 64, table lines; power of two, 2..256; IDX_W = log2(ENTRIES).
- CNT_BITS, 2, saturating-counter width; MSB=1 means predict taken.
- PREDICT_JALR, 0, 1 = jalr resolutions train/allocate like jal; 0 = jalr never trained and always treated as a mispredict when taken.
- PERF_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  ADDR_W  current fetch PC
- if_pred_taken  out  1  predicted taken for if_pc
- if_pred_target  out  ADDR_W  predicted target (if_pc+4 when not taken)
- ex_valid  in  1  EX holds a resolved branch/jal/jalr this cycle
- ex_stall  in  1  EX frozen (DCACHE stall); blocks update
- ex_pc  in  ADDR_W  PC of resolving instruction
- ex_is_jump  in  1  jal (unconditional)
- ex_is_jalr  in  1  jalr
- ex_taken  in  1  actual outcome
- ex_target  in  ADDR_W  actual target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_pred_target  in  ADDR_W  predicted target carried down the pipe
- mispredict  out  1  redirect required; flush IF/ID and ID/EX
- redirect_pc  out  ADDR_W  correct next PC
- perf_branches  out  PERF_W  resolved control-flow count
- perf_mispredicts  out  PERF_W  mispredict count

Behaviour:
- Index and tag: idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==if_tag.
  - if_pred_taken = hit && cnt[idx][MSB].
  - if_pred_target = if_pred_taken ? target[idx] : if_pc+4 (modulo 2^ADDR_W).
- Update enable: upd = ex_valid && !ex_stall && !(ex_is_jalr && !PREDICT_JALR). Table writes on the rising clk edge when upd=1. Exactly one update per instruction.
- Update on hit:
  - jal (or jalr when enabled): cnt set to all-ones.
  - otherwise: ex_taken ? saturating increment : saturating decrement.
  - target is overwritten with ex_target when ex_taken.
- Update on miss:
  - ex_taken: allocate. valid=1, tag, target=ex_target. cnt = all-ones for jump, otherwise 2^(CNT_BITS-1) (weakly taken).
  - !ex_taken: no write.
- Mispredict (combinational):
  - mispredict = ex_valid && !ex_stall && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4. redirect_pc = 0 when mispredict=0.
- Simultaneous lookup and update on the same index: the lookup returns the pre-update contents (no bypass).
- Perf counters:
  - perf_branches increments when ex_valid && !ex_stall.
  - perf_mispredicts increments when mispredict.
  - Both saturate at all-ones.
- Reset (async, any time including mid-update):
  - all valid=0, all cnt=2^(CNT_BITS-1)-1 (weakly not-taken), targets/tags=0, perf counters=0.
  - Outputs follow immediately: if_pred_taken=0, if_pred_target=if_pc+4, mispredict=0 given ex_valid=0.
  - After reset deassertion, the first update is honoured on the next edge.
- ex_stall high: no table or perf write; mispredict forced 0 until the stall releases.

Decomposition:
- Shared package (bp_pkg): the CNT_BITS-derived constants CNT_MAX, CNT_WEAK_T, CNT_WEAK_NT; index/tag slice helper functions; a saturating inc/dec function.
- One sub-module is natural: bp_sat_counter, a combinational next-value function of (cnt, taken, force_max).
- Table storage stays flops in the top so it can be cleared by async reset.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0, if_pred_target=0x104; perf counters=0.
- Branch at 0x100 resolves taken to 0x80 with pred 0 -> mispredict=1, redirect_pc=0x80. Next cycle lookup 0x100 -> taken, target 0x80; perf_mispredicts=1.
- Same branch not-taken twice after allocation (cnt 10->01->00) -> prediction flips to not-taken after the first; a third not-taken keeps cnt 00 (saturates).
- jal at 0x200 to 0x40 -> cnt all-ones. Aliasing PC 0x200+4*ENTRIES taken to 0x300 -> replaces line; lookup 0x200 now misses.
- Update asserted with ex_stall=1 for 3 cycles, then released -> exactly one table write, perf_branches +1, mispredict 0 during the stall.
- jalr taken with PREDICT_JALR=0 -> no allocation, mispredict=1 when pred differs. Also assert rst_n low mid-stream -> all predictions cleared asynchronously.
